// File: rtl/ym3438_pkg.sv
// Shared register map and control-bit layout for the YM3438 timer stage.
package ym3438_pkg;

    localparam logic [7:0] REG_TA_HI    = 8'h24;
    localparam logic [7:0] REG_TA_LO    = 8'h25;
    localparam logic [7:0] REG_TB       = 8'h26;
    localparam logic [7:0] REG_TMR_CTRL = 8'h27;

    localparam logic [1:0] CSM_MODE = 2'b10;

    localparam int CTRL_LOAD_A  = 0;
    localparam int CTRL_LOAD_B  = 1;
    localparam int CTRL_FEN_A   = 2;
    localparam int CTRL_FEN_B   = 3;
    localparam int CTRL_RST_A   = 4;
    localparam int CTRL_RST_B   = 5;
    localparam int CTRL_MODE_LO = 6;

    // Stored part of reg 0x27; the reset-flag bits are strobes and never held.
    typedef struct packed {
        logic [1:0] ch3_mode;
        logic       fen_b;
        logic       fen_a;
        logic       load_b;
        logic       load_a;
    } tmr_ctrl_t;

endpackage

// File: rtl/ym3438_timer_cnt.sv
// One YM3438 timer: up-counter with reload, load-bit edge detect and sticky overflow flag.
module ym3438_timer_cnt
    import ym3438_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             MCLK,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic             flag_en,
    input  logic             flag_clr,
    input  logic [WIDTH-1:0] reload,
    output logic             flag,
    output logic             ovf
);

    logic [WIDTH-1:0] cnt;
    logic             load_q;
    logic             load_edge;
    logic             overflow;

    // A rising load bit reloads the counter and suppresses any tick on that edge.
    always_comb begin
        load_edge = load & ~load_q;
        overflow  = load & tick & ~load_edge & (cnt == '1);
    end

    // Overflow setting the flag takes priority over a clear strobe on the same edge.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            cnt    <= '0;
            load_q <= 1'b0;
            ovf    <= 1'b0;
            flag   <= 1'b0;
        end else begin
            load_q <= load;
            ovf    <= overflow;
            if (load_edge) begin
                cnt <= reload;
            end else if (load & tick) begin
                cnt <= overflow ? reload : cnt + {{(WIDTH-1){1'b0}}, 1'b1};
            end
            if (overflow & flag_en) begin
                flag <= 1'b1;
            end else if (flag_clr) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ym3438_timers.sv
// Timer A / Timer B block: address latch, bank-0 decode of 0x24-0x27, timer B prescaler
// and CSM key-on gating around two ym3438_timer_cnt instances.
module ym3438_timers
    import ym3438_pkg::*;
#(
    parameter int TA_W   = 10,
    parameter int TB_W   = 8,
    parameter int TB_PRE = 4
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       write_addr_en,
    input  logic       write_data_en,
    input  logic [7:0] data_bus,
    input  logic       bank,
    output logic       timer_a,
    output logic       timer_b,
    output logic       ovf_a,
    output logic       csm_key,
    output logic [1:0] ch3_mode
);

    logic [7:0]        addr;
    logic              addr_valid;
    logic [7:0]        ta_hi;
    logic [1:0]        ta_lo;
    logic [TB_W-1:0]   tb_reload;
    logic [TA_W-1:0]   ta_reload;
    tmr_ctrl_t         ctrl;
    logic [TB_PRE-1:0] prescaler;
    logic              data_wr;
    logic              clr_a;
    logic              clr_b;
    logic              tick_b;
    logic              ovf_b_unused;

    always_comb begin
        data_wr   = write_data_en & addr_valid;
        clr_a     = data_wr & (addr == REG_TMR_CTRL) & data_bus[CTRL_RST_A];
        clr_b     = data_wr & (addr == REG_TMR_CTRL) & data_bus[CTRL_RST_B];
        tick_b    = sample_tick & (prescaler == '1);
        ta_reload = {ta_hi, ta_lo};
    end

    // A data write uses the address latched before this edge, so a simultaneous
    // address write only steers later data writes.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            addr       <= 8'h00;
            addr_valid <= 1'b0;
            ta_hi      <= '0;
            ta_lo      <= '0;
            tb_reload  <= '0;
            ctrl       <= '0;
            prescaler  <= '0;
        end else begin
            if (write_addr_en) begin
                addr       <= data_bus;
                addr_valid <= ~bank;
            end
            if (data_wr) begin
                case (addr)
                    REG_TA_HI:    ta_hi     <= data_bus;
                    REG_TA_LO:    ta_lo     <= data_bus[1:0];
                    REG_TB:       tb_reload <= data_bus;
                    REG_TMR_CTRL: ctrl      <= {data_bus[CTRL_MODE_LO+1:CTRL_MODE_LO],
                                                data_bus[CTRL_FEN_B:CTRL_LOAD_A]};
                    default:      ;
                endcase
            end
            if (sample_tick) begin
                prescaler <= prescaler + {{(TB_PRE-1){1'b0}}, 1'b1};
            end
        end
    end

    ym3438_timer_cnt #(.WIDTH(TA_W)) u_timer_a (
        .MCLK     (MCLK),
        .reset    (reset),
        .tick     (sample_tick),
        .load     (ctrl.load_a),
        .flag_en  (ctrl.fen_a),
        .flag_clr (clr_a),
        .reload   (ta_reload),
        .flag     (timer_a),
        .ovf      (ovf_a)
    );

    ym3438_timer_cnt #(.WIDTH(TB_W)) u_timer_b (
        .MCLK     (MCLK),
        .reset    (reset),
        .tick     (tick_b),
        .load     (ctrl.load_b),
        .flag_en  (ctrl.fen_b),
        .flag_clr (clr_b),
        .reload   (tb_reload),
        .flag     (timer_b),
        .ovf      (ovf_b_unused)
    );

    assign ch3_mode = ctrl.ch3_mode;
    assign csm_key  = ovf_a & (ctrl.ch3_mode == CSM_MODE);

endmodule

// File: tb/tb_ym3438_timers.sv
// Self-checking bench for ym3438_timers: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the timer registers.
module tb_ym3438_timers;

    logic       MCLK = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       write_addr_en;
    logic       write_data_en;
    logic [7:0] data_bus;
    logic       bank;
    logic       timer_a;
    logic       timer_b;
    logic       ovf_a;
    logic       csm_key;
    logic [1:0] ch3_mode;

    int total = 0;
    int bad   = 0;

    int m_addr, m_valid, m_ta, m_tb;
    int m_load_a, m_load_b, m_fen_a, m_fen_b, m_mode;
    int m_cnt_a, m_cnt_b, m_prev_a, m_prev_b, m_pre;
    int m_flag_a, m_flag_b, m_ovf_a;

    ym3438_timers dut (
        .MCLK          (MCLK),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .write_addr_en (write_addr_en),
        .write_data_en (write_data_en),
        .data_bus      (data_bus),
        .bank          (bank),
        .timer_a       (timer_a),
        .timer_b       (timer_b),
        .ovf_a         (ovf_a),
        .csm_key       (csm_key),
        .ch3_mode      (ch3_mode)
    );

    always #5 MCLK = ~MCLK;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advances the reference model by one MCLK edge using the inputs held at that edge.
    task automatic modelStep();
        int d;
        int tick_b;
        int wrap_a;
        int wrap_b;
        int clr_a;
        int clr_b;
        d = int'(data_bus);
        if (reset) begin
            m_addr = 0; m_valid = 0; m_ta = 0; m_tb = 0;
            m_load_a = 0; m_load_b = 0; m_fen_a = 0; m_fen_b = 0; m_mode = 0;
            m_cnt_a = 0; m_cnt_b = 0; m_prev_a = 0; m_prev_b = 0; m_pre = 0;
            m_flag_a = 0; m_flag_b = 0; m_ovf_a = 0;
            return;
        end
        tick_b = (sample_tick && m_pre == 15) ? 1 : 0;
        wrap_a = 0;
        wrap_b = 0;
        if (m_load_a == 1 && m_prev_a == 0) m_cnt_a = m_ta;
        else if (m_load_a == 1 && sample_tick) begin
            if (m_cnt_a == 1023) begin m_cnt_a = m_ta; wrap_a = 1; end
            else m_cnt_a = m_cnt_a + 1;
        end
        if (m_load_b == 1 && m_prev_b == 0) m_cnt_b = m_tb;
        else if (m_load_b == 1 && tick_b == 1) begin
            if (m_cnt_b == 255) begin m_cnt_b = m_tb; wrap_b = 1; end
            else m_cnt_b = m_cnt_b + 1;
        end
        clr_a = (write_data_en && m_valid == 1 && m_addr == 'h27 && (d / 16) % 2 == 1) ? 1 : 0;
        clr_b = (write_data_en && m_valid == 1 && m_addr == 'h27 && (d / 32) % 2 == 1) ? 1 : 0;
        if (wrap_a == 1 && m_fen_a == 1) m_flag_a = 1; else if (clr_a == 1) m_flag_a = 0;
        if (wrap_b == 1 && m_fen_b == 1) m_flag_b = 1; else if (clr_b == 1) m_flag_b = 0;
        m_prev_a = m_load_a;
        m_prev_b = m_load_b;
        if (sample_tick) m_pre = (m_pre + 1) % 16;
        if (write_data_en && m_valid == 1) begin
            case (m_addr)
                'h24: m_ta = d * 4 + m_ta % 4;
                'h25: m_ta = (m_ta / 4) * 4 + d % 4;
                'h26: m_tb = d;
                'h27: begin
                    m_load_a = d % 2;
                    m_load_b = (d / 2) % 2;
                    m_fen_a  = (d / 4) % 2;
                    m_fen_b  = (d / 8) % 2;
                    m_mode   = d / 64;
                end
                default: ;
            endcase
        end
        if (write_addr_en) begin
            m_addr  = d;
            m_valid = bank ? 0 : 1;
        end
        m_ovf_a = wrap_a;
    endtask

    task automatic applyStimulus(input bit rst, input bit wa, input bit wd,
                                 input logic [7:0] d, input bit bk, input bit tk);
        @(negedge MCLK);
        reset         = rst;
        write_addr_en = wa;
        write_data_en = wd;
        data_bus      = d;
        bank          = bk;
        sample_tick   = tk;
        @(posedge MCLK);
        modelStep();
        #1;
        checkOutput("model_timer_a", int'(timer_a), m_flag_a);
        checkOutput("model_timer_b", int'(timer_b), m_flag_b);
        checkOutput("model_ovf_a", int'(ovf_a), m_ovf_a);
        checkOutput("model_csm_key", int'(csm_key), (m_ovf_a == 1 && m_mode == 2) ? 1 : 0);
        checkOutput("model_ch3_mode", int'(ch3_mode), m_mode);
    endtask

    task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
        applyStimulus(0, 1, 0, a, 0, 0);
        applyStimulus(0, 0, 1, d, 0, 0);
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 8'h00, 0, 1);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
    endtask

    initial begin
        int first_b;
        int r;
        logic [7:0] d;
        logic [7:0] addr_pick [5];
        reset = 1'b1; sample_tick = 1'b0; write_addr_en = 1'b0;
        write_data_en = 1'b0; data_bus = 8'h00; bank = 1'b0;
        addr_pick[0] = 8'h24; addr_pick[1] = 8'h25; addr_pick[2] = 8'h26;
        addr_pick[3] = 8'h27; addr_pick[4] = 8'h30;

        doReset();
        checkOutput("reset_timer_a", int'(timer_a), 0);
        checkOutput("reset_ch3_mode", int'(ch3_mode), 0);

        // Reload 1023 overflows on every tick.
        writeReg(8'h24, 8'hFF); writeReg(8'h25, 8'h03); writeReg(8'h27, 8'h05);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        runTicks(1);
        checkOutput("t1_timer_a", int'(timer_a), 1);
        checkOutput("t1_ovf_a", int'(ovf_a), 1);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput("t1_ovf_a_pulse_end", int'(ovf_a), 0);

        // TA=1020: overflow on the 4th tick, clear strobe, then overflow coinciding with clear.
        doReset();
        writeReg(8'h24, 8'hFF); writeReg(8'h25, 8'h00); writeReg(8'h27, 8'h05);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        runTicks(3);
        checkOutput("t2_no_ovf_yet", int'(timer_a), 0);
        runTicks(1);
        checkOutput("t2_timer_a_set", int'(timer_a), 1);
        writeReg(8'h27, 8'h15);
        checkOutput("t2_timer_a_clr", int'(timer_a), 0);
        applyStimulus(0, 1, 0, 8'h27, 0, 1);
        runTicks(2);
        applyStimulus(0, 0, 1, 8'h15, 0, 1);
        checkOutput("t2_set_wins", int'(timer_a), 1);
        checkOutput("t2_set_wins_ovf", int'(ovf_a), 1);

        // TB=0xFE needs two prescaler wraps.
        doReset();
        writeReg(8'h26, 8'hFE); writeReg(8'h27, 8'h0A);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        first_b = 0;
        for (int i = 1; i <= 64 && first_b == 0; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0, 1);
            if (timer_b) first_b = i;
        end
        checkOutput("t3_ticks_to_b", first_b, 32);
        checkOutput("t3_on_wrap", first_b % 16, 0);

        // Bank-1 and out-of-range addresses must not touch the registers.
        doReset();
        writeReg(8'h24, 8'hFF); writeReg(8'h25, 8'h03);
        applyStimulus(0, 1, 0, 8'h24, 1, 0);
        applyStimulus(0, 0, 1, 8'h55, 0, 0);
        writeReg(8'h30, 8'h00);
        writeReg(8'h27, 8'h05);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        runTicks(1);
        checkOutput("t4_reload_kept", int'(ovf_a), 1);
        runTicks(1);
        checkOutput("t4_reload_kept2", int'(ovf_a), 1);

        // CSM mode with flag-enable A off.
        doReset();
        writeReg(8'h24, 8'hFF); writeReg(8'h25, 8'h03); writeReg(8'h27, 8'h81);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) begin
            runTicks(1);
            checkOutput("t5_csm_key", int'(csm_key), 1);
            checkOutput("t5_timer_a_off", int'(timer_a), 0);
            checkOutput("t5_mode", int'(ch3_mode), 2);
        end

        // Freeze at 1020 with load off, then reset in the middle of counting.
        doReset();
        writeReg(8'h24, 8'hFA); writeReg(8'h25, 8'h00); writeReg(8'h27, 8'h01);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        runTicks(20);
        writeReg(8'h27, 8'h04);
        runTicks(10);
        checkOutput("t6_frozen", int'(timer_a), 0);
        writeReg(8'h27, 8'h85);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        runTicks(30);
        checkOutput("t6_pre_reset_flag", int'(timer_a), 1);
        applyStimulus(1, 0, 0, 8'h00, 0, 1);
        checkOutput("t6_reset_timer_a", int'(timer_a), 0);
        checkOutput("t6_reset_mode", int'(ch3_mode), 0);
        checkOutput("t6_reset_csm", int'(csm_key), 0);
        runTicks(1);
        checkOutput("t6_after_reset_ovf", int'(ovf_a), 0);

        // Random traffic against the model; reload data is biased to keep overflows frequent.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                applyStimulus(1, 0, 0, 8'h00, 0, 0);
            end else if (r < 15) begin
                applyStimulus(0, 1, 0, addr_pick[$urandom_range(0, 4)],
                              ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
            end else if (r < 30) begin
                d = 8'($urandom);
                if (m_addr == 'h24) d = d | 8'hF8;
                if (m_addr == 'h26) d = d | 8'hF0;
                applyStimulus(0, 0, 1, d, 0, $urandom_range(0, 1) == 1);
            end else begin
                applyStimulus(0, 0, 0, 8'($urandom), 0, $urandom_range(0, 9) < 6);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
